// File: rtl/change_dispenser.sv
// change_dispenser: pays requested change one coin at a time as timed
// solenoid pulses. It tracks hopper stock, substitutes smaller coins greedily
// when a denomination runs out, and reports any unpaid remainder as shortfall.
module change_dispenser #(
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 4,
  parameter int STOCK_W      = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               change_valid,
  input  logic [8:0]         quart,
  input  logic [8:0]         dim,
  input  logic [8:0]         nick,
  input  logic               refill,
  input  logic [STOCK_W-1:0] refill_q,
  input  logic [STOCK_W-1:0] refill_d,
  input  logic [STOCK_W-1:0] refill_n,
  output logic               busy,
  output logic               eject_q,
  output logic               eject_d,
  output logic               eject_n,
  output logic               done,
  output logic [14:0]        shortfall,
  output logic [STOCK_W-1:0] stock_q,
  output logic [STOCK_W-1:0] stock_d,
  output logic [STOCK_W-1:0] stock_n
);

  localparam int CNT_W = 16;

  typedef enum logic [2:0] {IDLE, SELECT, PULSE, GAP, DONE} state_t;
  typedef enum logic [1:0] {C_Q, C_D, C_N} coin_t;

  state_t             state_q, state_d;
  coin_t              coin_q, coin_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [14:0]        owed_q, owed_d;
  logic [14:0]        sf_q, sf_d;
  logic [STOCK_W-1:0] qstk_q, qstk_d;
  logic [STOCK_W-1:0] dstk_q, dstk_d;
  logic [STOCK_W-1:0] nstk_q, nstk_d;

  function automatic logic [STOCK_W-1:0] sat_add(input logic [STOCK_W-1:0] a,
                                                 input logic [STOCK_W-1:0] b);
    logic [STOCK_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[STOCK_W] ? '1 : s[STOCK_W-1:0];
  endfunction

  // State and datapath registers; reset clears stock and drops ejects at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      coin_q  <= C_Q;
      cnt_q   <= '0;
      owed_q  <= '0;
      sf_q    <= '0;
      qstk_q  <= '0;
      dstk_q  <= '0;
      nstk_q  <= '0;
    end else begin
      state_q <= state_d;
      coin_q  <= coin_d;
      cnt_q   <= cnt_d;
      owed_q  <= owed_d;
      sf_q    <= sf_d;
      qstk_q  <= qstk_d;
      dstk_q  <= dstk_d;
      nstk_q  <= nstk_d;
    end
  end

  // Next-state logic: request/refill intake, greedy coin choice, pulse/gap timing.
  always_comb begin
    state_d = state_q;
    coin_d  = coin_q;
    cnt_d   = cnt_q;
    owed_d  = owed_q;
    sf_d    = sf_q;
    qstk_d  = qstk_q;
    dstk_d  = dstk_q;
    nstk_d  = nstk_q;
    case (state_q)
      IDLE: begin
        // Refill lands on the same edge as a request so SELECT sees it.
        if (refill) begin
          qstk_d = sat_add(qstk_q, refill_q);
          dstk_d = sat_add(dstk_q, refill_d);
          nstk_d = sat_add(nstk_q, refill_n);
        end
        if (change_valid) begin
          owed_d  = 15'(quart) * 15'd25 + 15'(dim) * 15'd10 + 15'(nick) * 15'd5;
          state_d = SELECT;
        end
      end
      SELECT: begin
        cnt_d = '0;
        if (owed_q >= 15'd25 && qstk_q != '0) begin
          coin_d  = C_Q;
          qstk_d  = qstk_q - STOCK_W'(1);
          owed_d  = owed_q - 15'd25;
          state_d = PULSE;
        end else if (owed_q >= 15'd10 && dstk_q != '0) begin
          coin_d  = C_D;
          dstk_d  = dstk_q - STOCK_W'(1);
          owed_d  = owed_q - 15'd10;
          state_d = PULSE;
        end else if (owed_q >= 15'd5 && nstk_q != '0) begin
          coin_d  = C_N;
          nstk_d  = nstk_q - STOCK_W'(1);
          owed_d  = owed_q - 15'd5;
          state_d = PULSE;
        end else begin
          state_d = DONE;
        end
      end
      PULSE: begin
        if (cnt_q == CNT_W'(PULSE_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = GAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = SELECT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        sf_d    = owed_q;
        owed_d  = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign eject_q   = (state_q == PULSE) && (coin_q == C_Q);
  assign eject_d   = (state_q == PULSE) && (coin_q == C_D);
  assign eject_n   = (state_q == PULSE) && (coin_q == C_N);
  assign shortfall = sf_q;
  assign stock_q   = qstk_q;
  assign stock_d   = dstk_q;
  assign stock_n   = nstk_q;

endmodule
